// File: rtl/mac_pkg.sv
// Shared definitions for the pipelined multiply/accumulate unit:
// operation encodings and the accumulator width derivation.
package mac_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_MAC    = 2'd1,
        OP_HORNER = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    // The accumulator holds a full DW x DW product plus guard bits for headroom.
    function automatic int acc_width(input int dw, input int guard);
        return 2 * dw + guard;
    endfunction

endpackage

// File: rtl/mac_pipe_unit_if.sv
// Operand/result handshake bundle between the operand sequencer (master)
// and the MAC pipeline (slave).
interface mac_pipe_unit_if #(
    parameter int DW    = 8,
    parameter int ACC_W = 17
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [DW-1:0]     in_a;
    logic [DW-1:0]     in_b;
    logic [2*DW-1:0]   in_add;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;

    modport master (
        output in_valid, in_op, in_a, in_b, in_add, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_add, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mac_sat_add.sv
// W-bit unsigned adder with carry-out; optionally clamps the sum to
// all-ones when the carry is set.
module mac_sat_add #(
    parameter int W        = 17,
    parameter int SATURATE = 0
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_carry
);
    logic [W:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_carry = w_full[W];

    generate
        if (SATURATE != 0) begin : g_sat
            assign o_sum = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
        end else begin : g_wrap
            assign o_sum = w_full[W-1:0];
        end
    endgenerate
endmodule

// File: rtl/mac_pipe_unit.sv
// Two-stage handshaked MAC: S1 multiplies, S2 adds into the accumulator and
// retires last-tagged ops into a registered result slot.
module mac_pipe_unit
    import mac_pkg::*;
#(
    parameter int DW       = 8,
    parameter int GUARD    = 1,
    parameter int SATURATE = 0
) (
    input  logic           clk,
    input  logic           reset,
    mac_pipe_unit_if.slave bus
);
    localparam int ACC_W = acc_width(DW, GUARD);
    localparam int PW    = ACC_W + DW;

    // S1 stage registers
    logic              r_s1_valid;
    op_e               r_s1_op;
    logic              r_s1_last;
    logic [2*DW-1:0]   r_s1_add;
    logic [ACC_W-1:0]  r_s1_prod;
    logic              r_s1_povf;

    // Accumulator and result slot
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf;
    logic              r_out_valid;
    logic [ACC_W-1:0]  r_out_data;
    logic              r_out_ovf;

    logic              w_adv;
    logic              w_in_ready;
    logic              w_accept;
    op_e               w_in_op;
    logic [ACC_W-1:0]  w_mop;
    logic [PW-1:0]     w_prod_full;
    logic              w_prod_hi_nz;
    logic [ACC_W-1:0]  w_prod;
    logic [ACC_W-1:0]  w_add_a;
    logic [ACC_W-1:0]  w_add_b;
    logic [ACC_W-1:0]  w_sum;
    logic              w_carry;
    logic [ACC_W-1:0]  w_acc_next;
    logic              w_ovf_next;

    assign w_in_op  = op_e'(bus.in_op);
    assign w_adv    = !r_out_valid || bus.out_ready;
    // HORNER multiplies by the accumulator, so it must wait for S1 to drain.
    assign w_in_ready = w_adv && !((w_in_op == OP_HORNER) && r_s1_valid);
    assign w_accept   = bus.in_valid && w_in_ready;

    assign w_mop        = (w_in_op == OP_HORNER) ? r_acc : ACC_W'(bus.in_a);
    assign w_prod_full  = PW'(w_mop) * PW'(bus.in_b);
    assign w_prod_hi_nz = |w_prod_full[PW-1:ACC_W];
    assign w_prod       = ((SATURATE != 0) && w_prod_hi_nz) ? {ACC_W{1'b1}}
                                                             : w_prod_full[ACC_W-1:0];

    always_comb begin
        w_add_a = r_s1_prod;
        w_add_b = ACC_W'(r_s1_add);
        if (r_s1_op == OP_MAC) begin
            w_add_a = r_acc;
            w_add_b = r_s1_prod;
        end
    end

    mac_sat_add #(
        .W        (ACC_W),
        .SATURATE (SATURATE)
    ) u_add (
        .i_a     (w_add_a),
        .i_b     (w_add_b),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // LOAD restarts the sticky flag; MAC/HORNER keep accumulating it.
    always_comb begin
        w_acc_next = w_sum;
        w_ovf_next = r_ovf | r_s1_povf | w_carry;
        case (r_s1_op)
            OP_CLEAR: begin
                w_acc_next = '0;
                w_ovf_next = 1'b0;
            end
            OP_LOAD:  w_ovf_next = r_s1_povf | w_carry;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= OP_LOAD;
            r_s1_last   <= 1'b0;
            r_s1_add    <= '0;
            r_s1_prod   <= '0;
            r_s1_povf   <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_adv) begin
            if (r_s1_valid) begin
                r_acc <= w_acc_next;
                r_ovf <= w_ovf_next;
            end
            if (r_s1_valid && r_s1_last) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_next;
                r_out_ovf   <= w_ovf_next;
            end else begin
                r_out_valid <= 1'b0;
            end
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_op   <= w_in_op;
                r_s1_last <= bus.in_last;
                r_s1_add  <= bus.in_add;
                r_s1_prod <= w_prod;
                r_s1_povf <= w_prod_hi_nz;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_mac_pipe_unit.sv
// Scoreboard bench: wrap-mode and saturating instances receive identical
// beats; each has its own expected-result queue drained by a monitor.
module tb_mac_pipe_unit;
    import mac_pkg::*;

    typedef struct {
        logic [16:0] data;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t q_w[$];
    exp_t q_s[$];

    mac_pipe_unit_if #(.DW(8), .ACC_W(17)) if_w ();
    mac_pipe_unit_if #(.DW(8), .ACC_W(17)) if_s ();

    mac_pipe_unit #(.DW(8), .GUARD(1), .SATURATE(0)) u_dut_w (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if_w)
    );

    mac_pipe_unit #(.DW(8), .GUARD(1), .SATURATE(1)) u_dut_s (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] add, input logic last);
        if_w.in_valid = v; if_s.in_valid = v;
        if_w.in_op    = op; if_s.in_op   = op;
        if_w.in_a     = a;  if_s.in_a    = a;
        if_w.in_b     = b;  if_s.in_b    = b;
        if_w.in_add   = add; if_s.in_add = add;
        if_w.in_last  = last; if_s.in_last = last;
    endtask

    task automatic set_ready(input logic r);
        if_w.out_ready = r;
        if_s.out_ready = r;
    endtask

    // Present one beat, wait (bounded) for in_ready, push expected results if last.
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] add, input logic last,
                        input logic [16:0] ew, input logic ow,
                        input logic [16:0] es, input logic os,
                        output int stalls);
        exp_t e;
        int   k;
        drive(1'b1, op, a, b, add, last);
        k = 0;
        @(negedge clk);
        while (!if_w.in_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (k == 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout op=%0d actual=stalled required=accepted", op);
        end
        stalls = k;
        if (last) begin
            e.data = ew; e.ovf = ow; q_w.push_back(e);
            e.data = es; e.ovf = os; q_s.push_back(e);
        end
        @(posedge clk);
        #1;
        if_w.in_valid = 1'b0;
        if_s.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if_w.out_valid && if_w.out_ready) begin
            if (q_w.size() == 0) begin
                chk("wrap_unexpected_result", 32'(if_w.out_data), 32'hFFFF_FFFF);
            end else begin
                e = q_w.pop_front();
                chk("wrap_out_data", 32'(if_w.out_data), 32'(e.data));
                chk("wrap_out_ovf", 32'(if_w.out_ovf), 32'(e.ovf));
                $display("wrap result data=%0d ovf=%0d", if_w.out_data, if_w.out_ovf);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if_s.out_valid && if_s.out_ready) begin
            if (q_s.size() == 0) begin
                chk("sat_unexpected_result", 32'(if_s.out_data), 32'hFFFF_FFFF);
            end else begin
                e = q_s.pop_front();
                chk("sat_out_data", 32'(if_s.out_data), 32'(e.data));
                chk("sat_out_ovf", 32'(if_s.out_ovf), 32'(e.ovf));
                $display("sat  result data=%0d ovf=%0d", if_s.out_data, if_s.out_ovf);
            end
        end
    end

    task automatic check_idle_reset(input string tag);
        @(negedge clk);
        chk({tag, "_out_valid_w"}, 32'(if_w.out_valid), 32'd0);
        chk({tag, "_out_data_w"},  32'(if_w.out_data),  32'd0);
        chk({tag, "_out_ovf_w"},   32'(if_w.out_ovf),   32'd0);
        chk({tag, "_in_ready_w"},  32'(if_w.in_ready),  32'd1);
        chk({tag, "_out_valid_s"}, 32'(if_s.out_valid), 32'd0);
        chk({tag, "_in_ready_s"},  32'(if_s.in_ready),  32'd1);
    endtask

    initial begin
        int st;
        int total;
        int k;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, OP_LOAD, 8'd0, 8'd0, 16'd0, 1'b0);
        set_ready(1'b1);
        repeat (3) @(posedge clk);
        check_idle_reset("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: single LOAD, result two edges after accept
        send(OP_LOAD, 8'd3, 8'd4, 16'd5, 1'b1, 17'd17, 1'b0, 17'd17, 1'b0, st);
        @(negedge clk);
        chk("latency_edge1_out_valid", 32'(if_w.out_valid), 32'd0);
        @(negedge clk);
        chk("latency_edge2_out_valid", 32'(if_w.out_valid), 32'd1);
        repeat (2) @(posedge clk); #1;

        // 2: dot product at one beat per clock, wraps / saturates
        total = 0;
        send(OP_LOAD, 8'd255, 8'd255, 16'd0, 1'b0, 17'd0, 1'b0, 17'd0, 1'b0, st);
        total += st;
        send(OP_MAC, 8'd255, 8'd255, 16'd0, 1'b0, 17'd0, 1'b0, 17'd0, 1'b0, st);
        total += st;
        send(OP_MAC, 8'd255, 8'd255, 16'd0, 1'b1, 17'd64003, 1'b1, 17'd131071, 1'b1, st);
        total += st;
        chk("dot_product_stalls", 32'(total), 32'd0);
        repeat (3) @(posedge clk); #1;

        // 3: Horner 2x^2+3x+1 at x=5, then a MAC continuing from the retired acc
        send(OP_LOAD, 8'd0, 8'd0, 16'd2, 1'b0, 17'd0, 1'b0, 17'd0, 1'b0, st);
        send(OP_HORNER, 8'd0, 8'd5, 16'd3, 1'b0, 17'd0, 1'b0, 17'd0, 1'b0, st);
        chk("horner1_stalls", 32'(st), 32'd1);
        send(OP_HORNER, 8'd0, 8'd5, 16'd1, 1'b1, 17'd66, 1'b0, 17'd66, 1'b0, st);
        chk("horner2_stalls", 32'(st), 32'd1);
        send(OP_MAC, 8'd1, 8'd1, 16'd0, 1'b1, 17'd67, 1'b0, 17'd67, 1'b0, st);
        repeat (3) @(posedge clk); #1;

        // 4/5: backpressure, then release on the edge a queued last-op retires
        set_ready(1'b0);
        send(OP_LOAD, 8'd1, 8'd1, 16'd0, 1'b1, 17'd1, 1'b0, 17'd1, 1'b0, st);
        send(OP_LOAD, 8'd2, 8'd3, 16'd1, 1'b1, 17'd7, 1'b0, 17'd7, 1'b0, st);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(if_w.in_ready), 32'd0);
            chk("bp_out_valid", 32'(if_w.out_valid), 32'd1);
            chk("bp_out_data", 32'(if_w.out_data), 32'd1);
        end
        @(posedge clk); #1;
        set_ready(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("simul_out_valid", 32'(if_w.out_valid), 32'd1);
        chk("simul_out_data", 32'(if_w.out_data), 32'd7);
        @(negedge clk);
        chk("drained_out_valid", 32'(if_w.out_valid), 32'd0);
        @(posedge clk); #1;

        // 6: reset with S1 full and a result pending
        set_ready(1'b0);
        send(OP_LOAD, 8'd9, 8'd9, 16'd0, 1'b1, 17'd81, 1'b0, 17'd81, 1'b0, st);
        send(OP_MAC, 8'd1, 8'd1, 16'd0, 1'b0, 17'd0, 1'b0, 17'd0, 1'b0, st);
        @(negedge clk);
        chk("pre_reset_out_valid", 32'(if_w.out_valid), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1'b0, OP_MAC, 8'd0, 8'd0, 16'd0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q_w.delete();
        q_s.delete();
        check_idle_reset("midreset");
        @(posedge clk); #1;
        set_ready(1'b1);
        send(OP_MAC, 8'd2, 8'd3, 16'd0, 1'b1, 17'd6, 1'b0, 17'd6, 1'b0, st);

        k = 0;
        while ((q_w.size() != 0 || q_s.size() != 0) && k < 20) begin
            @(posedge clk);
            k++;
        end
        if (k == 20) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", q_w.size() + q_s.size());
        end
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
